seg_mux_scheduler: RTL and testbench
====================================

# seg_mux_scheduler

Time-multiplexing scheduler for the dual seven-segment display. It alternates a single shared hex-to-segment decoder between two 4-bit digit sources and drives the two digit-enable transistors. A programmable blanking interval sits between digits to suppress ghosting. It sits between the digit sources (switch inputs / adder result nibbles) and the shared segment decoder in the top level.

## Interface
- ON_CYCLES, 24000: clock cycles each digit is lit; must be ≥1.
- BLANK_CYCLES, 240: clock cycles both digits are dark after each digit; must be ≥1.
- clk  input  1  system clock (internal oscillator).
- reset  input  1  synchronous, active-high reset.
- en  input  1  run enable; low freezes the schedule and darkens both digits.
- hex1  input  4  digit 1 source nibble.
- hex2  input  4  digit 2 source nibble.
- hex_out  output  4  nibble to the shared segment decoder.
- digit_sel  output  1  0 = hex_out belongs to digit 1, 1 = digit 2.
- hex1_num  output  1  digit 1 enable, active-low (PNP drive).
- hex2_num  output  1  digit 2 enable, active-low (PNP drive).
- frame_tick  output  1  one-cycle pulse at the start of each frame.

## Operation
- FSM states: SHOW1 → BLANK1 → SHOW2 → BLANK2 → SHOW1.
- Down-counter `cnt`, width $clog2(max(ON_CYCLES, BLANK_CYCLES)+1).
  - Loaded with ON_CYCLES-1 on entry to a SHOW state and BLANK_CYCLES-1 on entry to a BLANK state.
  - The state advances on the edge where cnt==0 and en==1.
- SHOW1 entry: hex_out←hex1, digit_sel←0, hex1_num←0, hex2_num←1.
- SHOW2 entry: hex_out←hex2, digit_sel←1, hex2_num←0, hex1_num←1.
- BLANK entry: hex1_num←1 and hex2_num←1. hex_out and digit_sel hold.
- Source nibbles are sampled only on SHOW entry. Changes to hex1/hex2 mid-interval do not reach hex_out until the next corresponding SHOW entry.
- frame_tick is 1 for exactly the first cycle of SHOW1, including the first SHOW1 after reset.
- At most one enable is low in any cycle. Both enables are never low simultaneously.
- en=0 sampled at an edge:
  - State and cnt hold.
  - Both enables go high, registered.
  - hex_out and digit_sel hold.
  - frame_tick is 0.
- en returning to 1: the enables are restored per the current state on the next edge, and counting resumes from the held cnt. No interval restarts.
- All outputs are registered.

## Timing
- Reset values: state=BLANK2, cnt=0, hex_out=0, digit_sel=0, hex1_num=1, hex2_num=1, frame_tick=0.
- First edge after reset deasserts (en=1) enters SHOW1: hex1 is captured, hex1_num=0, frame_tick=1.
- Each SHOW lasts exactly ON_CYCLES cycles and each BLANK exactly BLANK_CYCLES cycles while en=1.
- Frame period is 2·(ON_CYCLES+BLANK_CYCLES) cycles. frame_tick period equals the frame period.
- Latency from a hex input change to hex_out: up to one frame.
- Reset asserted mid-operation takes effect on the next edge and overrides en. Outputs go to reset values on that edge.
- en=0 and cnt==0 on the same edge: hold wins, no transition.
- Reset and en=0 together: reset wins.

## Test plan
- Reset then run (ON=4, BLANK=2, en=1, hex1=4, hex2=5):
  - frame_tick pulses every 12 cycles.
  - hex1_num low for 4 cycles with hex_out=4, digit_sel=0.
  - Both enables high for 2 cycles.
  - hex2_num low for 4 cycles with hex_out=5, digit_sel=1.
  - Both enables high for 2 cycles.
- Mid-show input change: hex1 changes 4→8 in the 2nd SHOW1 cycle → hex_out stays 4 through that SHOW1 and BLANK1, and shows 8 at the next SHOW1 entry.
- en pause: en=0 for 5 cycles in the 3rd SHOW2 cycle →
  - Both enables high on the next edge and for the whole pause.
  - After en=1, hex2_num is low for the remaining 2 SHOW2 cycles.
  - Frame stretches to 17 cycles.
- Reset mid-frame: assert during BLANK1 → the next edge gives all outputs at reset values. The first cycle after release is SHOW1 with frame_tick=1.
- Exclusivity sweep: 200 cycles with random hex1/hex2 and random en → hex1_num and hex2_num are never both 0. hex_out always equals the nibble sampled at the last SHOW entry.
- Extremes: hex1=15, hex2=0 with ON=1, BLANK=1 → frame period 4 cycles, each digit lit exactly 1 cycle, frame_tick every 4 cycles.

Source files
------------

// File: rtl/seg_mux_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_mux_scheduler_if
// Description : Signal bundle between the digit sources, the display
//               multiplex scheduler and the shared segment decoder.
//               master : scheduler side (consumes en/hex1/hex2, drives the
//                        display-facing outputs)
//               slave  : environment side (drives en/hex1/hex2, observes
//                        the display-facing outputs)
//   en         run enable
//   hex1/hex2  digit 1 / digit 2 source nibbles
//   hex_out    nibble routed to the shared decoder
//   digit_sel  0 = digit 1 owns hex_out, 1 = digit 2
//   hex1_num   digit 1 enable, active-low
//   hex2_num   digit 2 enable, active-low
//   frame_tick one-cycle pulse at the start of each frame
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_mux_scheduler_if;
    logic       en;
    logic [3:0] hex1;
    logic [3:0] hex2;
    logic [3:0] hex_out;
    logic       digit_sel;
    logic       hex1_num;
    logic       hex2_num;
    logic       frame_tick;

    modport master (
        input  en, hex1, hex2,
        output hex_out, digit_sel, hex1_num, hex2_num, frame_tick
    );

    modport slave (
        output en, hex1, hex2,
        input  hex_out, digit_sel, hex1_num, hex2_num, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_mux_scheduler
// Description : Time-multiplexes one shared hex-to-segment decoder between
//               two digit sources. Each digit is lit for ON_CYCLES clocks,
//               followed by BLANK_CYCLES clocks with both digits dark to
//               suppress ghosting. Frame = SHOW1, BLANK1, SHOW2, BLANK2.
// Ports       : clk        system clock
//               reset      synchronous, active-high reset
//               bus.en     run enable; low freezes schedule, darkens digits
//               bus.hex1   digit 1 source nibble (sampled on SHOW1 entry)
//               bus.hex2   digit 2 source nibble (sampled on SHOW2 entry)
//               bus.hex_out    nibble to the shared decoder
//               bus.digit_sel  0 = digit 1, 1 = digit 2
//               bus.hex1_num   digit 1 enable, active-low
//               bus.hex2_num   digit 2 enable, active-low
//               bus.frame_tick pulse on the first cycle of SHOW1
// Revision    : 1.0 - initial release
// ============================================================================
module seg_mux_scheduler #(
    parameter int ON_CYCLES    = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  wire logic           clk,
    input  wire logic           reset,
    seg_mux_scheduler_if.master bus
);

    localparam int c_MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_ON_LOAD    = c_CNT_W'(ON_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LOAD = c_CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SHOW1  = 2'd0,
        S_BLANK1 = 2'd1,
        S_SHOW2  = 2'd2,
        S_BLANK2 = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_hex_out;
    logic                 r_digit_sel;
    logic                 r_hex1_num;
    logic                 r_hex2_num;
    logic                 r_frame_tick;

    // Next-state values
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]           w_hex_out_nxt;
    logic                 w_digit_sel_nxt;
    logic                 w_hex1_num_nxt;
    logic                 w_hex2_num_nxt;
    logic                 w_frame_tick_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Parking in BLANK2 with cnt=0 makes the first enabled edge
            // after reset enter SHOW1 and raise frame_tick.
            r_state      <= S_BLANK2;
            r_cnt        <= '0;
            r_hex_out    <= 4'h0;
            r_digit_sel  <= 1'b0;
            r_hex1_num   <= 1'b1;
            r_hex2_num   <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hex_out    <= w_hex_out_nxt;
            r_digit_sel  <= w_digit_sel_nxt;
            r_hex1_num   <= w_hex1_num_nxt;
            r_hex2_num   <= w_hex2_num_nxt;
            r_frame_tick <= w_frame_tick_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Defaults: hold schedule, data path and select; digits dark;
        // no frame pulse.
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_hex_out_nxt    = r_hex_out;
        w_digit_sel_nxt  = r_digit_sel;
        w_hex1_num_nxt   = 1'b1;
        w_hex2_num_nxt   = 1'b1;
        w_frame_tick_nxt = 1'b0;

        if (bus.en) begin
            if (r_cnt == '0) begin
                // Interval expired: move to the next phase and load its length.
                case (r_state)
                    S_SHOW1: begin
                        w_state_nxt = S_BLANK1;
                        w_cnt_nxt   = c_BLANK_LOAD;
                    end
                    S_BLANK1: begin
                        w_state_nxt     = S_SHOW2;
                        w_cnt_nxt       = c_ON_LOAD;
                        w_hex_out_nxt   = bus.hex2;
                        w_digit_sel_nxt = 1'b1;
                        w_hex2_num_nxt  = 1'b0;
                    end
                    S_SHOW2: begin
                        w_state_nxt = S_BLANK2;
                        w_cnt_nxt   = c_BLANK_LOAD;
                    end
                    default: begin // S_BLANK2
                        w_state_nxt      = S_SHOW1;
                        w_cnt_nxt        = c_ON_LOAD;
                        w_hex_out_nxt    = bus.hex1;
                        w_digit_sel_nxt  = 1'b0;
                        w_hex1_num_nxt   = 1'b0;
                        w_frame_tick_nxt = 1'b1;
                    end
                endcase
            end else begin
                // Mid-interval: keep counting. Enables are re-derived from
                // the current state so they come back after an en pause
                // without restarting the interval.
                w_cnt_nxt      = r_cnt - 1'b1;
                w_hex1_num_nxt = (r_state == S_SHOW1) ? 1'b0 : 1'b1;
                w_hex2_num_nxt = (r_state == S_SHOW2) ? 1'b0 : 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.hex_out    = r_hex_out;
    assign bus.digit_sel  = r_digit_sel;
    assign bus.hex1_num   = r_hex1_num;
    assign bus.hex2_num   = r_hex2_num;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_mux_scheduler
// Description : Self-checking bench for seg_mux_scheduler. Two instances:
//               dut_a (ON=4, BLANK=2) takes directed and random stimulus,
//               dut_b (ON=1, BLANK=1) runs free with hex1=15, hex2=0.
//               A frame-position model predicts every output each cycle;
//               literal expectations at fixed cycles pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg_mux_scheduler;

    localparam int c_ON_A = 4;
    localparam int c_BL_A = 2;
    localparam int c_ON_B = 1;
    localparam int c_BL_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg_mux_scheduler_if ifa ();
    seg_mux_scheduler_if ifb ();

    seg_mux_scheduler #(.ON_CYCLES(c_ON_A), .BLANK_CYCLES(c_BL_A)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ifa)
    );

    seg_mux_scheduler #(.ON_CYCLES(c_ON_B), .BLANK_CYCLES(c_BL_B)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the schedule is a function of k, the number of
    // enabled edges since reset. Position p = (k-1) mod frame length
    // identifies which part of the frame is showing.
    // ------------------------------------------------------------------
    typedef struct packed {
        int         k;
        logic [3:0] hex;
        logic       sel;
        logic       n1;
        logic       n2;
        logic       tick;
    } mdl_t;

    function automatic mdl_t mdl_step(input mdl_t m, input logic r, input logic en,
                                      input logic [3:0] h1, input logic [3:0] h2,
                                      input int on_c, input int bl_c);
        mdl_t o = m;
        int   p;
        int   f = 2 * (on_c + bl_c);
        if (r) begin
            o.k = 0; o.hex = 4'h0; o.sel = 1'b0;
            o.n1 = 1'b1; o.n2 = 1'b1; o.tick = 1'b0;
        end else if (!en) begin
            o.n1 = 1'b1; o.n2 = 1'b1; o.tick = 1'b0;
        end else begin
            o.k    = m.k + 1;
            p      = (o.k - 1) % f;
            o.tick = (p == 0);
            if (p == 0) begin
                o.hex = h1; o.sel = 1'b0;
            end
            if (p == on_c + bl_c) begin
                o.hex = h2; o.sel = 1'b1;
            end
            o.n1 = !(p < on_c);
            o.n2 = !((p >= on_c + bl_c) && (p < 2 * on_c + bl_c));
        end
        return o;
    endfunction

    mdl_t ma = '0;
    mdl_t mb = '0;

    // Model update on the edge from the inputs seen at that edge, then
    // compare all outputs shortly after the edge.
    always @(posedge clk) begin
        ma = mdl_step(ma, rst, ifa.en, ifa.hex1, ifa.hex2, c_ON_A, c_BL_A);
        mb = mdl_step(mb, rst, ifb.en, ifb.hex1, ifb.hex2, c_ON_B, c_BL_B);
        #1;
        check("a_hex_out",    ifa.hex_out,    ma.hex);
        check("a_digit_sel",  ifa.digit_sel,  ma.sel);
        check("a_hex1_num",   ifa.hex1_num,   ma.n1);
        check("a_hex2_num",   ifa.hex2_num,   ma.n2);
        check("a_frame_tick", ifa.frame_tick, ma.tick);
        check("a_exclusive",  ifa.hex1_num | ifa.hex2_num, 1);
        check("b_hex_out",    ifb.hex_out,    mb.hex);
        check("b_digit_sel",  ifb.digit_sel,  mb.sel);
        check("b_hex1_num",   ifb.hex1_num,   mb.n1);
        check("b_hex2_num",   ifb.hex2_num,   mb.n2);
        check("b_frame_tick", ifb.frame_tick, mb.tick);
        check("b_exclusive",  ifb.hex1_num | ifb.hex2_num, 1);
    end

    task automatic step_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus; inputs change only on the falling edge. Comments "En"
    // name the rising edge most recently passed (E1 = first after reset).
    // ------------------------------------------------------------------
    initial begin
        ifa.en = 1'b1; ifa.hex1 = 4'd4;  ifa.hex2 = 4'd5;
        ifb.en = 1'b1; ifb.hex1 = 4'd15; ifb.hex2 = 4'd0;
        step_n(2);
        rst = 1'b0;

        step_n(1); // E1: SHOW1 entry on both instances
        check("lit_a_tick_first", ifa.frame_tick, 1);
        check("lit_a_n1_show1",   ifa.hex1_num,   0);
        check("lit_a_n2_show1",   ifa.hex2_num,   1);
        check("lit_a_hex_show1",  ifa.hex_out,    4);
        check("lit_a_sel_show1",  ifa.digit_sel,  0);
        check("lit_b_hex_show1",  ifb.hex_out,    15);
        check("lit_b_n1_show1",   ifb.hex1_num,   0);

        step_n(1); // E2: second SHOW1 cycle; change hex1 mid-show
        check("lit_a_tick_once",  ifa.frame_tick, 0);
        check("lit_b_blank_n1",   ifb.hex1_num,   1);
        ifa.hex1 = 4'd8;

        step_n(1); // E3: dut_b SHOW2
        check("lit_a_hex_hold",   ifa.hex_out,    4);
        check("lit_b_hex_show2",  ifb.hex_out,    0);
        check("lit_b_n2_show2",   ifb.hex2_num,   0);

        step_n(2); // E5: dut_a BLANK1, dut_b next frame
        check("lit_a_blank_n1",   ifa.hex1_num,   1);
        check("lit_a_blank_n2",   ifa.hex2_num,   1);
        check("lit_a_blank_hex",  ifa.hex_out,    4);
        check("lit_b_tick_4",     ifb.frame_tick, 1);

        step_n(2); // E7: dut_a SHOW2
        check("lit_a_hex_show2",  ifa.hex_out,    5);
        check("lit_a_sel_show2",  ifa.digit_sel,  1);
        check("lit_a_n2_show2",   ifa.hex2_num,   0);

        step_n(6); // E13: next frame shows the new hex1
        check("lit_a_tick_12",    ifa.frame_tick, 1);
        check("lit_a_hex_new",    ifa.hex_out,    8);

        step_n(7); // E20: 2nd SHOW2 cycle of frame 2; pause for 5 edges
        ifa.en = 1'b0;
        step_n(1); // E21
        check("lit_a_pause_n2",   ifa.hex2_num,   1);
        step_n(4); // E25
        check("lit_a_pause_end",  ifa.hex2_num,   1);
        check("lit_a_pause_sel",  ifa.digit_sel,  1);
        ifa.en = 1'b1;
        step_n(1); // E26: remaining SHOW2 cycles resume
        check("lit_a_resume1",    ifa.hex2_num,   0);
        step_n(1); // E27
        check("lit_a_resume2",    ifa.hex2_num,   0);
        step_n(1); // E28: BLANK2
        check("lit_a_resume_blk", ifa.hex2_num,   1);
        step_n(2); // E30: frame stretched to 17 cycles
        check("lit_a_tick_17",    ifa.frame_tick, 1);

        step_n(4); // E34: BLANK1; assert reset mid-frame
        check("lit_a_blank1_n1",  ifa.hex1_num,   1);
        rst = 1'b1;
        step_n(1); // E35: reset values
        check("lit_a_rst_hex",    ifa.hex_out,    0);
        check("lit_a_rst_sel",    ifa.digit_sel,  0);
        check("lit_a_rst_n1",     ifa.hex1_num,   1);
        check("lit_a_rst_n2",     ifa.hex2_num,   1);
        check("lit_a_rst_tick",   ifa.frame_tick, 0);
        rst = 1'b0;
        step_n(1); // E36: SHOW1 again with frame_tick
        check("lit_a_rel_tick",   ifa.frame_tick, 1);
        check("lit_a_rel_n1",     ifa.hex1_num,   0);
        check("lit_a_rel_hex",    ifa.hex_out,    8);

        // Random sweep: random nibbles and en; exclusivity and data
        // tracking are covered by the per-cycle compare.
        for (int i = 0; i < 200; i++) begin
            ifa.hex1 = 4'($urandom_range(0, 15));
            ifa.hex2 = 4'($urandom_range(0, 15));
            ifa.en   = ($urandom_range(0, 3) != 0);
            step_n(1);
        end

        step_n(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
